mem_port_ctrl: RTL

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_ctrl.sv
// Single-port memory access controller: byte/half/word requests to a 32-bit RAM
// with a one-deep in-flight stage and a 2-entry in-order response FIFO.
module mem_port_ctrl #(
    parameter int unsigned RAM_DEPTH = 2048,
    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_addr,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_wem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    logic        w_err;
    logic        w_accept;
    logic        w_issue;
    logic [2:0]  w_outstanding;

    logic        r_if_valid;
    logic        r_if_read;
    logic        r_if_err;
    logic [1:0]  r_if_size;
    logic [1:0]  r_if_off;
    logic [31:0] w_if_shift;
    logic [31:0] w_if_rdata;

    logic [31:0] r_fifo_rdata [2];
    logic        r_fifo_err   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        w_fifo_empty;
    logic        w_rsp_valid;
    logic        w_fire;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;

    always_comb begin
        unique case (cmd_size)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = cmd_addr[0];
            2'd2:    w_err = (cmd_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    // Entries in the in-flight stage count against capacity so a stalled
    // consumer can never see more than two responses queued.
    assign w_outstanding = {1'b0, r_count} + {2'b00, r_if_valid};
    assign cmd_ready     = ~rst & (w_outstanding < 3'd2);
    assign w_accept      = cmd_valid & cmd_ready;
    assign w_issue       = w_accept & ~w_err;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_issue) begin
            ram_en   = 1'b1;
            ram_we   = cmd_write;
            ram_addr = cmd_addr[RAM_AW+1:2];
            if (cmd_write) begin
                unique case (cmd_size)
                    2'd0: begin
                        ram_wem = 4'b0001 << cmd_addr[1:0];
                        ram_din = {4{cmd_wdata[7:0]}};
                    end
                    2'd1: begin
                        ram_wem = 4'b0011 << cmd_addr[1:0];
                        ram_din = {2{cmd_wdata[15:0]}};
                    end
                    default: begin
                        ram_wem = 4'b1111;
                        ram_din = cmd_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_read  <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_size  <= '0;
            r_if_off   <= '0;
        end else begin
            r_if_valid <= w_accept;
            if (w_accept) begin
                r_if_read <= ~cmd_write;
                r_if_err  <= w_err;
                r_if_size <= cmd_size;
                r_if_off  <= cmd_addr[1:0];
            end
        end
    end

    assign w_if_shift = ram_dout >> {r_if_off, 3'b000};

    always_comb begin
        w_if_rdata = '0;
        if (r_if_read && !r_if_err) begin
            unique case (r_if_size)
                2'd0:    w_if_rdata = {24'h0, w_if_shift[7:0]};
                2'd1:    w_if_rdata = {16'h0, (r_if_off[1] ? ram_dout[31:16] : ram_dout[15:0])};
                default: w_if_rdata = ram_dout;
            endcase
        end
    end

    assign w_fifo_empty = (r_count == 2'd0);
    assign w_rsp_valid  = ~rst & (~w_fifo_empty | r_if_valid);
    assign w_fire       = w_rsp_valid & rsp_ready;
    assign w_pop        = w_fire & ~w_fifo_empty;
    // An in-flight result consumed straight off the bypass never touches the FIFO.
    assign w_bypass     = w_fire & w_fifo_empty;
    assign w_push       = r_if_valid & ~w_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_rdata[r_wr_ptr] <= w_if_rdata;
                r_fifo_err[r_wr_ptr]   <= r_if_err;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_comb begin
        rsp_valid = w_rsp_valid;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (w_rsp_valid) begin
            if (w_fifo_empty) begin
                rsp_rdata = w_if_rdata;
                rsp_err   = r_if_err;
            end else begin
                rsp_rdata = r_fifo_rdata[r_rd_ptr];
                rsp_err   = r_fifo_err[r_rd_ptr];
            end
        end
    end

endmodule
